// File: rtl/axi_lite_rd_sram_if.sv
// rtl/axi_lite_rd_sram_if.sv - AXI-Lite read-channel bundle (AR + R) between fetch master and SRAM responder.
interface axi_lite_rd_sram_if;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  modport master (
    output araddr, arvalid, rready,
    input  arready, rdata, rresp, rvalid
  );

  modport slave (
    input  araddr, arvalid, rready,
    output arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axi_lite_rd_sram.sv
// rtl/axi_lite_rd_sram.sv - single-outstanding AXI-Lite read responder over a word SRAM, LFSR-jittered latency.
module axi_lite_rd_sram #(
  parameter logic [31:0] ADDR_BASE   = 32'h30000000,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          MIN_LAT     = 1,
  parameter int          RAND_LAT    = 0,
  parameter logic [7:0]  LFSR_SEED   = 8'hA5
) (
  input  logic                      clk,
  input  logic                      reset,
  axi_lite_rd_sram_if.slave         axi,
  input  logic                      bd_wen,
  input  logic [31:0]               bd_addr,
  input  logic [31:0]               bd_wdata
);

  localparam int          AW   = $clog2(DEPTH_WORDS);
  localparam int          CW   = $clog2(MIN_LAT + 4) + 1;
  localparam logic [31:0] SPAN = 32'(DEPTH_WORDS * 4);

  typedef enum logic [1:0] {IDLE, DELAY, RESP} state_t;

  state_t          state, state_nxt;
  logic [7:0]      lfsr;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   lat_m1;
  logic [31:0]     addr_q;
  logic [31:0]     mem [DEPTH_WORDS];

  logic            ar_hs, load_resp, r_hs;
  logic            rd_hit, bd_hit;
  logic [AW-1:0]   rd_idx, bd_idx;
  logic [31:0]     rd_word;

  // The subtraction is only trusted once addr >= ADDR_BASE, so low addresses cannot wrap into range.
  function automatic logic in_range(input logic [31:0] a);
    logic [31:0] off;
    off = a - ADDR_BASE;
    return (a >= ADDR_BASE) && (off < SPAN) && (a[1:0] == 2'b00);
  endfunction

  function automatic logic [AW-1:0] word_idx(input logic [31:0] a);
    return AW'((a - ADDR_BASE) >> 2);
  endfunction

  assign rd_hit  = in_range(addr_q);
  assign rd_idx  = word_idx(addr_q);
  assign bd_hit  = in_range(bd_addr);
  assign bd_idx  = word_idx(bd_addr);
  // A backdoor write landing on the load edge wins over the stale array contents.
  assign rd_word = (bd_wen && bd_hit && (bd_idx == rd_idx)) ? bd_wdata : mem[rd_idx];
  assign lat_m1  = CW'(MIN_LAT - 1) + ((RAND_LAT != 0) ? CW'(lfsr[1:0]) : '0);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (ar_hs)      state_nxt = DELAY;
      DELAY:   if (cnt == '0)  state_nxt = RESP;
      RESP:    if (r_hs)       state_nxt = IDLE;
      default:                 state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ar_hs     = (state == IDLE)  && axi.arvalid && axi.arready;
    load_resp = (state == DELAY) && (cnt == '0);
    r_hs      = (state == RESP)  && axi.rvalid && axi.rready;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr        <= LFSR_SEED;
      cnt         <= '0;
      addr_q      <= '0;
      axi.arready <= 1'b0;
      axi.rvalid  <= 1'b0;
      axi.rdata   <= '0;
      axi.rresp   <= 2'b00;
    end else begin
      lfsr        <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      axi.arready <= (state_nxt == IDLE);
      axi.rvalid  <= (state_nxt == RESP);
      if (ar_hs) begin
        addr_q <= axi.araddr;
        cnt    <= lat_m1;
      end else if ((state == DELAY) && (cnt != '0)) begin
        cnt <= cnt - 1'b1;
      end
      if (load_resp) begin
        axi.rdata <= rd_hit ? rd_word : 32'h0;
        axi.rresp <= rd_hit ? 2'b00 : 2'b10;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (bd_wen && bd_hit) mem[bd_idx] <= bd_wdata;
  end

endmodule

// File: doc/axi_lite_rd_sram.md
Name: axi_lite_rd_sram

Overview:
- AXI-Lite read-channel responder (slave) backing instruction fetch.
- Answers the fetch unit's single-outstanding AR/R requests from a word-addressed SRAM array.
- Response latency is configurable with optional LFSR-randomised delay, so the fetch handshake is stressed under variable timing.
- Out-of-range or misaligned addresses return SLVERR.
- A backdoor write port lets the bench or loader preload the array.

Parameters:
- ADDR_BASE, 32'h30000000, byte address of word 0.
- DEPTH_WORDS, 1024, number of 32-bit words (power of two).
- MIN_LAT, 1, minimum cycles from AR handshake edge to rvalid rising (>=1).
- RAND_LAT, 0, 1 = add lfsr[1:0] (0..3) extra cycles per request.
- LFSR_SEED, 8'hA5, nonzero reset value of the 8-bit LFSR.

Ports:
- clk  in  1  clock.
- reset  in  1  reset.
- axi_araddr  in  32  read address.
- axi_arvalid  in  1  address valid.
- axi_arready  out  1  address accept.
- axi_rdata  out  32  read data.
- axi_rresp  out  2  00 OKAY, 10 SLVERR.
- axi_rvalid  out  1  data valid.
- axi_rready  in  1  master ready for data.
- bd_wen  in  1  backdoor write enable.
- bd_addr  in  32  backdoor byte address; same decode as AR.
- bd_wdata  in  32  backdoor write data.

Behaviour:
- Clock/reset: clk; reset synchronous, active-high.
- Reset values: axi_arready=0, axi_rvalid=0, axi_rdata=0, axi_rresp=00, state=IDLE, LFSR=LFSR_SEED, delay counter=0. The array is not reset.
- arready rises on the first edge after reset deasserts.
- LFSR: 8-bit Fibonacci, taps 8,6,5,4. Advances every non-reset cycle regardless of state.
- State IDLE: axi_arready=1.
  - On arvalid&&arready at edge E: latch araddr; arready<=0.
  - L = MIN_LAT + (RAND_LAT ? lfsr[1:0] : 0), sampled at E.
  - cnt<=L-1; go to DELAY.
- State DELAY:
  - cnt!=0: cnt<=cnt-1.
  - cnt==0: decode the latched address, drive rdata/rresp, set rvalid<=1, go to RESP.
  - rvalid is therefore first visible after edge E+L.
- Decode:
  - off = addr - ADDR_BASE.
  - Hit when addr >= ADDR_BASE, off < DEPTH_WORDS*4, and addr[1:0]==0. On a hit, rdata = mem[off>>2] and rresp = 00.
  - Otherwise rdata = 0 and rresp = 10.
  - Offset arithmetic is 32-bit unsigned; addr < ADDR_BASE must not alias via wrap-around.
- State RESP:
  - rvalid, rdata and rresp are held stable until rready is sampled high.
  - On rvalid&&rready: rvalid<=0, arready<=1, go to IDLE.
  - Back-to-back minimum: a new AR is accepted one cycle after the R handshake.
- Single outstanding only: arready is 0 during DELAY and RESP. arvalid held high by the master during that time is ignored until IDLE.
- rready asserted early (before rvalid) is legal. The handshake completes on the first cycle where rvalid=1.
- Backdoor write:
  - bd_wen with a hit address writes mem at that edge, in any state. A miss address is dropped silently.
  - Write to the same word as an in-flight read, at or before the DELAY cnt==0 edge: the read returns the new data (write-first at that edge).
  - A write after the response is latched does not change the held rdata.
- Reset mid-transaction (DELAY or RESP): everything returns to reset values next edge and the pending response is discarded; no rvalid is emitted for it.

Test Plan:
- Preload mem[0]=32'h00000413 via backdoor; MIN_LAT=1, RAND_LAT=0; AR 0x30000000 handshake at edge E -> rvalid=1 after edge E+1, rdata=32'h00000413, rresp=00.
- MIN_LAT=3; rready held low 5 cycles after rvalid, then high -> rdata/rresp stable throughout; rvalid drops the edge after rready; arready=1 the same edge.
- AR 0x2FFFFFFC, AR 0x30001000 (DEPTH 1024), AR 0x30000002 -> each rresp=10, rdata=0, no array read.
- RAND_LAT=1, seed 8'hA5, 100 sequential reads of preloaded pattern mem[i]=i*32'h01010101 -> every rdata correct; AR-to-rvalid delays within 1..4 and match the LFSR model.
- Backdoor write 32'hDEADBEEF to the target word during DELAY of a read of that word -> response returns 32'hDEADBEEF.
- Assert reset while in RESP with rvalid=1 -> after the reset edge rvalid=0 and arready=0; arready=1 one edge after reset drops; the next read behaves normally.
